// File: rtl/reg_file_wr_arbiter.sv
// Write-port controller for the register file: clears entries 1..N-1 after reset
// or on request, then round-robins the single write port between requesters A and B.
module reg_file_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  input  logic                  a_wvalid,
  output logic                  a_wready,
  input  logic [ADDR_WIDTH-1:0] a_waddr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_wvalid,
  output logic                  b_wready,
  input  logic [ADDR_WIDTH-1:0] b_waddr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  init_done
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_START = ADDR_WIDTH'(1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last_b;

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt == '1) state_nxt = RUN;
      RUN:     if (clr_req)   state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // On a tie the requester that was not granted last wins.
  always_comb begin
    a_wready  = 1'b0;
    b_wready  = 1'b0;
    init_done = (state == RUN);
    if (state == RUN && !clr_req) begin
      a_wready = a_wvalid && (!b_wvalid || last_b);
      b_wready = b_wvalid && (!a_wvalid || !last_b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= CNT_START;
      last_b   <= 1'b1;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rf_wen   <= 1'b1;
          rf_waddr <= cnt;
          rf_wdata <= '0;
          cnt      <= (cnt == '1) ? CNT_START : cnt + CNT_START;
        end
        RUN: begin
          if (clr_req) begin
            cnt    <= CNT_START;
            rf_wen <= 1'b0;
          end else if (a_wvalid && a_wready) begin
            rf_wen   <= (a_waddr != '0);
            rf_waddr <= a_waddr;
            rf_wdata <= a_wdata;
            last_b   <= 1'b0;
          end else if (b_wvalid && b_wready) begin
            rf_wen   <= (b_waddr != '0);
            rf_waddr <= b_waddr;
            rf_wdata <= b_wdata;
            last_b   <= 1'b1;
          end else begin
            rf_wen <= 1'b0;
          end
        end
        default: rf_wen <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter: expected register-file writes are queued
// by the stimulus and popped by a monitor whenever rf_wen is presented.
module tb_reg_file_wr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_req;
  logic          a_wvalid, a_wready;
  logic [AW-1:0] a_waddr;
  logic [DW-1:0] a_wdata;
  logic          b_wvalid, b_wready;
  logic [AW-1:0] b_waddr;
  logic [DW-1:0] b_wdata;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          init_done;

  reg_file_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .a_wvalid(a_wvalid), .a_wready(a_wready), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_wvalid(b_wvalid), .b_wready(b_wready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  // Register file model: r0 ignores writes; other entries start non-zero.
  logic [DW-1:0] model [NREG];
  bit            model_init = 1'b0;
  always @(posedge clk) begin
    if (!model_init) begin
      for (int i = 0; i < NREG; i++) model[i] <= 32'hBAD0_0000 | DW'(i);
      model[0]   <= '0;
      model_init <= 1'b1;
    end else if (rf_wen && rf_waddr != '0) begin
      model[rf_waddr] <= rf_wdata;
    end
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (a_wvalid && b_wvalid) chk("ready_exclusive", 64'(a_wready && b_wready), 64'd0);
      if (rf_wen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_write: got addr %0d data 0x%0h, expected no write at %0t",
                   rf_waddr, rf_wdata, $time);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("sb_addr", 64'(rf_waddr), 64'(e.addr));
          chk("sb_data", 64'(rf_wdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int k = 1; k < NREG; k++) push(AW'(k), '0);
  endtask

  // Starts in CLEAR; ends just after the edge presenting the last clear write.
  task automatic clear_seq(input string tag);
    for (int k = 1; k < NREG; k++) begin
      chk({tag, "_ready_in_clear"}, 64'({a_wready, b_wready}), 64'd0);
      cyc();
      chk({tag, "_clr_wen"}, 64'(rf_wen), 64'd1);
      chk({tag, "_clr_addr"}, 64'(rf_waddr), 64'(k));
      chk({tag, "_init_done"}, 64'(init_done), 64'(k == NREG - 1));
    end
  endtask

  initial begin
    int unsigned a_idx, b_idx;
    bit          grant_b [8];
    grant_b = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; clr_req = 1'b0;
    a_wvalid = 1'b0; a_waddr = '0; a_wdata = '0;
    b_wvalid = 1'b0; b_waddr = '0; b_wdata = '0;
    repeat (3) cyc();
    chk("reset_wen", 64'(rf_wen), 64'd0);
    chk("reset_waddr", 64'(rf_waddr), 64'd0);
    chk("reset_wdata", 64'(rf_wdata), 64'd0);
    chk("reset_init_done", 64'(init_done), 64'd0);

    // Initial clear after reset
    push_clear();
    rst = 1'b0;
    clear_seq("init");
    cyc();
    chk("init_clear_end_wen", 64'(rf_wen), 64'd0);
    for (int i = 0; i < NREG; i++) chk("init_readback", 64'(model[i]), 64'd0);

    // A only
    a_wvalid = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
    #1;
    chk("aonly_a_ready", 64'(a_wready), 64'd1);
    chk("aonly_b_ready", 64'(b_wready), 64'd0);
    push(5'd5, 32'hDEAD_BEEF);
    cyc();
    a_wvalid = 1'b0;
    chk("aonly_wen", 64'(rf_wen), 64'd1);
    chk("aonly_waddr", 64'(rf_waddr), 64'd5);
    cyc();
    chk("aonly_readback_r5", 64'(model[5]), 64'hDEAD_BEEF);

    // B writes r0: handshake completes, no write enable
    b_wvalid = 1'b1; b_waddr = 5'd0; b_wdata = 32'h1234;
    #1;
    chk("r0_b_ready", 64'(b_wready), 64'd1);
    chk("r0_a_ready", 64'(a_wready), 64'd0);
    cyc();
    b_wvalid = 1'b0;
    chk("r0_wen", 64'(rf_wen), 64'd0);
    chk("r0_waddr", 64'(rf_waddr), 64'd0);
    chk("r0_wdata", 64'(rf_wdata), 64'h1234);

    // Both valid: B was granted last, so A goes first
    a_idx = 0; b_idx = 0;
    for (int i = 0; i < 8; i++) begin
      a_wvalid = (a_idx < 4); a_waddr = AW'(1 + a_idx); a_wdata = 32'hA000_0000 + DW'(1 + a_idx);
      b_wvalid = (b_idx < 4); b_waddr = AW'(9 + b_idx); b_wdata = 32'hB000_0000 + DW'(9 + b_idx);
      #1;
      chk("rr_a_ready", 64'(a_wready), 64'(!grant_b[i]));
      chk("rr_b_ready", 64'(b_wready), 64'(grant_b[i]));
      if (grant_b[i]) begin
        push(b_waddr, b_wdata);
        b_idx++;
      end else begin
        push(a_waddr, a_wdata);
        a_idx++;
      end
      cyc();
    end
    a_wvalid = 1'b0; b_wvalid = 1'b0;
    chk("rr_last_waddr", 64'(rf_waddr), 64'd12);
    cyc();
    for (int k = 1; k <= 4; k++) chk("rr_readback_a", 64'(model[k]), 64'(32'hA000_0000 + k));
    for (int k = 9; k <= 12; k++) chk("rr_readback_b", 64'(model[k]), 64'(32'hB000_0000 + k));

    // Clear request while A has a pending write
    a_wvalid = 1'b1; a_waddr = 5'd7; a_wdata = 32'h55;
    #1;
    chk("clr_pre_a_ready", 64'(a_wready), 64'd1);
    push(5'd7, 32'h55);
    cyc();
    clr_req = 1'b1; a_waddr = 5'd3; a_wdata = 32'h77;
    #1;
    chk("clr_a_ready_blocked", 64'(a_wready), 64'd0);
    chk("clr_init_done_before", 64'(init_done), 64'd1);
    push_clear();
    cyc();
    clr_req = 1'b0;
    chk("clr_init_done_fall", 64'(init_done), 64'd0);
    chk("clr_first_edge_wen", 64'(rf_wen), 64'd0);
    chk("clr_r7_written", 64'(model[7]), 64'h55);
    clear_seq("clr");
    chk("clr_pending_a_ready", 64'(a_wready), 64'd1);
    push(5'd3, 32'h77);
    cyc();
    a_wvalid = 1'b0;
    chk("clr_pending_waddr", 64'(rf_waddr), 64'd3);
    cyc();
    chk("clr_readback_r7", 64'(model[7]), 64'd0);
    chk("clr_readback_r3", 64'(model[3]), 64'h77);

    // Reset after the 10th clear write restarts the clear
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    push_clear();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("midrst_clr_addr", 64'(rf_waddr), 64'(k));
    end
    rst = 1'b1;
    cyc();
    exp_q.delete();
    chk("midrst_wen", 64'(rf_wen), 64'd0);
    chk("midrst_waddr", 64'(rf_waddr), 64'd0);
    chk("midrst_init_done", 64'(init_done), 64'd0);
    rst = 1'b0;
    push_clear();
    clear_seq("midrst");
    cyc();
    chk("midrst_end_wen", 64'(rf_wen), 64'd0);
    chk("midrst_readback_r3", 64'(model[3]), 64'd0);

    repeat (2) cyc();
    chk("sb_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
